// File: rtl/ssm3_fu.sv
// ssm3_fu: SM3 P0/P1 permutation unit (ssm3.p0 / ssm3.p1) for the execute stage.
// Either a single output-register pipeline or an iterative datapath with one shared rotator.
//
// Iterative FSM:
//   state | meaning
//   IDLE  | ready for a new op; on accept x/op/rd captured and acc <= x
//   ROT_A | acc <= acc ^ rol32(x, op ? 15 : 9)
//   ROT_B | acc <= acc ^ rol32(x, op ? 23 : 17)
//   DONE  | result presented on out_*, held until out_ready
module ssm3_fu #(
    parameter int XLEN      = 32,
    parameter bit ITERATIVE = 1'b0
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROT_A = 2'd1,
        ROT_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] n);
        logic [63:0] d;
        d = {v, v} << n;
        return d[63:32];
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [31:0] x;
    logic        unused_rs1;

    // Only the low word is an operand; the upper half of a 64-bit rs1 is ignored.
    assign x          = in_rs1[31:0];
    assign unused_rs1 = ^in_rs1;

    generate
        if (ITERATIVE == 1'b0) begin : g_pipe
            logic [31:0]     perm;
            logic            accept;
            logic            valid_q;
            logic [XLEN-1:0] result_q;
            logic [4:0]      rd_q;

            assign perm = in_op ? (x ^ rol32(x, 5'd15) ^ rol32(x, 5'd23))
                                : (x ^ rol32(x, 5'd9)  ^ rol32(x, 5'd17));

            assign in_ready = !g_reset && !flush && (!valid_q || out_ready);
            assign accept   = in_valid && in_ready;

            always_ff @(posedge g_clk) begin
                if (g_reset) begin
                    valid_q  <= 1'b0;
                    result_q <= '0;
                    rd_q     <= 5'd0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (accept) begin
                    valid_q  <= 1'b1;
                    result_q <= (in_rd == 5'd0) ? '0 : sext32(perm);
                    rd_q     <= in_rd;
                end else if (out_ready) begin
                    valid_q <= 1'b0;
                end
            end

            assign out_valid  = valid_q;
            assign out_result = result_q;
            assign out_rd     = rd_q;
        end else begin : g_iter
            state_t      state;
            state_t      state_nxt;
            logic        accept;
            logic [31:0] x_q;
            logic        op_q;
            logic [4:0]  rd_q;
            logic [31:0] acc;
            logic [4:0]  rot_amt;
            logic [31:0] rot;

            assign in_ready = !g_reset && !flush && (state == IDLE);
            assign accept   = in_valid && in_ready;

            always_ff @(posedge g_clk) begin
                if (g_reset) begin
                    state <= IDLE;
                end else begin
                    state <= state_nxt;
                end
            end

            always_comb begin
                state_nxt = state;
                case (state)
                    IDLE:    if (accept) state_nxt = ROT_A;
                    ROT_A:   state_nxt = ROT_B;
                    ROT_B:   state_nxt = DONE;
                    DONE:    if (out_ready) state_nxt = IDLE;
                    default: state_nxt = IDLE;
                endcase
                if (flush) begin
                    state_nxt = IDLE;
                end
            end

            // The single rotator: its amount is picked by state and the captured op.
            always_comb begin
                rot_amt = 5'd0;
                if (state == ROT_A) begin
                    rot_amt = op_q ? 5'd15 : 5'd9;
                end else if (state == ROT_B) begin
                    rot_amt = op_q ? 5'd23 : 5'd17;
                end
            end

            assign rot = rol32(x_q, rot_amt);

            always_ff @(posedge g_clk) begin
                if (g_reset) begin
                    x_q  <= 32'd0;
                    op_q <= 1'b0;
                    rd_q <= 5'd0;
                    acc  <= 32'd0;
                end else if (accept) begin
                    x_q  <= x;
                    op_q <= in_op;
                    rd_q <= in_rd;
                    acc  <= x;
                end else if (!flush && (state == ROT_A || state == ROT_B)) begin
                    acc <= acc ^ rot;
                end
            end

            assign out_valid  = (state == DONE);
            assign out_result = (rd_q == 5'd0) ? '0 : sext32(acc);
            assign out_rd     = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_ssm3_fu.sv
// Bench for ssm3_fu: all four XLEN/ITERATIVE variants, exercised one at a time against
// a transaction-level model (queue of expected results with ready cycles).
module tb_ssm3_fu;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        flush;
    logic        in_op;
    logic [63:0] in_rs1;
    logic [4:0]  in_rd;
    logic [3:0]  iv_v;
    logic [3:0]  or_v;
    logic [3:0]  ir_v;
    logic [3:0]  ov_v;
    logic [31:0] res_0, res_1;
    logic [63:0] res_2, res_3;
    logic [4:0]  rd_0, rd_1, rd_2, rd_3;
    logic [63:0] res_a [4];
    logic [4:0]  rd_a  [4];

    always #5 g_clk = ~g_clk;

    assign res_a[0] = {32'h0, res_0};
    assign res_a[1] = {32'h0, res_1};
    assign res_a[2] = res_2;
    assign res_a[3] = res_3;
    assign rd_a[0]  = rd_0;
    assign rd_a[1]  = rd_1;
    assign rd_a[2]  = rd_2;
    assign rd_a[3]  = rd_3;

    ssm3_fu #(.XLEN(32), .ITERATIVE(1'b0)) u_p32 (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .in_valid(iv_v[0]), .in_ready(ir_v[0]), .in_op(in_op), .in_rs1(in_rs1[31:0]), .in_rd(in_rd),
        .out_valid(ov_v[0]), .out_ready(or_v[0]), .out_result(res_0), .out_rd(rd_0));
    ssm3_fu #(.XLEN(32), .ITERATIVE(1'b1)) u_i32 (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .in_valid(iv_v[1]), .in_ready(ir_v[1]), .in_op(in_op), .in_rs1(in_rs1[31:0]), .in_rd(in_rd),
        .out_valid(ov_v[1]), .out_ready(or_v[1]), .out_result(res_1), .out_rd(rd_1));
    ssm3_fu #(.XLEN(64), .ITERATIVE(1'b0)) u_p64 (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .in_valid(iv_v[2]), .in_ready(ir_v[2]), .in_op(in_op), .in_rs1(in_rs1), .in_rd(in_rd),
        .out_valid(ov_v[2]), .out_ready(or_v[2]), .out_result(res_2), .out_rd(rd_2));
    ssm3_fu #(.XLEN(64), .ITERATIVE(1'b1)) u_i64 (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .in_valid(iv_v[3]), .in_ready(ir_v[3]), .in_op(in_op), .in_rs1(in_rs1), .in_rd(in_rd),
        .out_valid(ov_v[3]), .out_ready(or_v[3]), .out_result(res_3), .out_rd(rd_3));

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          rdy;
    } item_t;

    item_t       q[$];
    int          cyc;
    int          cur;
    int          n_checks;
    int          n_errors;
    int          n_acc;
    bit          prev_rst;
    bit          last_ov;
    logic [63:0] last_res;

    function automatic int xl(int i);
        return (i < 2) ? 32 : 64;
    endfunction

    function automatic int lat(int i);
        return (i % 2 == 1) ? 3 : 1;
    endfunction

    function automatic logic [31:0] rol(logic [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [63:0] ext(int i, logic [31:0] r);
        if (xl(i) == 64) return {{32{r[31]}}, r};
        return {32'h0, r};
    endfunction

    function automatic logic [63:0] ref_res(int i, bit op, logic [63:0] rs, logic [4:0] rd);
        logic [31:0] v;
        logic [31:0] r;
        v = rs[31:0];
        r = op ? (v ^ rol(v, 15) ^ rol(v, 23)) : (v ^ rol(v, 9) ^ rol(v, 17));
        if (rd == 5'd0) return 64'h0;
        return ext(i, r);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc%0d got %h want %h", tag, cur, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after negedge, check outputs, advance the model.
    task automatic step(input bit v, input bit op, input logic [63:0] rs, input logic [4:0] rd,
                        input bit ordy, input bit fl, input bit rst);
        bit    e_ir;
        bit    e_ov;
        item_t it;
        @(negedge g_clk);
        g_reset   = rst;
        flush     = fl;
        in_op     = op;
        in_rs1    = rs;
        in_rd     = rd;
        iv_v      = 4'b0;
        iv_v[cur] = v;
        or_v      = 4'hF;
        or_v[cur] = ordy;
        #1;
        e_ir = !rst && !fl && (q.size() == 0 || (lat(cur) == 1 && ordy));
        e_ov = (q.size() > 0) && (cyc >= q[0].rdy);
        chk("in_ready", {63'h0, ir_v[cur]}, {63'h0, e_ir});
        chk("out_valid", {63'h0, ov_v[cur]}, {63'h0, e_ov});
        if (e_ov && ov_v[cur]) begin
            chk("out_result", res_a[cur], q[0].res);
            chk("out_rd", {59'h0, rd_a[cur]}, {59'h0, q[0].rd});
        end
        if (prev_rst) begin
            chk("rst_result", res_a[cur], 64'h0);
            chk("rst_rd", {59'h0, rd_a[cur]}, 64'h0);
        end
        prev_rst = rst;
        last_ov  = ov_v[cur];
        last_res = res_a[cur];
        if (rst) begin
            q.delete();
        end else begin
            if (e_ov && ordy) void'(q.pop_front());
            if (fl) begin
                q.delete();
            end else if (v && e_ir) begin
                it.res = ref_res(cur, op, rs, rd);
                it.rd  = rd;
                it.rdy = cyc + lat(cur);
                q.push_back(it);
                n_acc++;
            end
        end
        cyc++;
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 1'b0, {$urandom, $urandom}, 5'($urandom), ordy, 1'b0, 1'b0);
    endtask

    task automatic run_one(input bit op, input logic [63:0] rs, input logic [4:0] rd,
                           input logic [63:0] exp);
        logic [63:0] got;
        got = 64'hBAD0_BAD0_BAD0_BAD0;
        step(1'b1, op, rs, rd, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            if (last_ov) begin
                got = last_res;
                break;
            end
        end
        chk("direct", got, exp);
    endtask

    initial begin
        int guard;
        g_reset  = 1'b1;
        flush    = 1'b0;
        in_op    = 1'b0;
        in_rs1   = 64'h0;
        in_rd    = 5'd0;
        iv_v     = 4'b0;
        or_v     = 4'hF;
        cyc      = 0;
        cur      = 0;
        n_checks = 0;
        n_errors = 0;
        n_acc    = 0;
        prev_rst = 1'b0;

        for (int d = 0; d < 4; d++) begin
            cur = d;
            step(1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b1);
            idle(1'b1);

            run_one(1'b0, 64'h1, 5'd1, ext(d, 32'h0002_0201));
            run_one(1'b1, 64'h1, 5'd1, ext(d, 32'h0080_8001));
            run_one(1'b0, 64'hFFFF_FFFF, 5'd1, ext(d, 32'hFFFF_FFFF));
            if (xl(d) == 64) begin
                run_one(1'b0, 64'hDEAD_BEEF_8000_0000, 5'd1, 64'hFFFF_FFFF_8001_0100);
                run_one(1'b0, 64'hDEAD_BEEF_0000_0001, 5'd1, 64'h0000_0000_0002_0201);
            end
            run_one(1'b1, 64'h1234_5678, 5'd0, 64'h0);

            // Backpressure: result held stable, no accept while full.
            step(1'b1, 1'b1, {$urandom, $urandom}, 5'd3, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < lat(d) + 4; k++)
                step(1'b1, 1'b0, {$urandom, $urandom}, 5'd7, 1'b0, 1'b0, 1'b0);
            idle(1'b1);
            idle(1'b1);

            // Stream of 8 ops with a draining consumer.
            n_acc = 0;
            guard = 0;
            while (n_acc < 8 && guard < 100) begin
                step(1'b1, 1'($urandom), {$urandom, $urandom}, 5'($urandom), 1'b1, 1'b0, 1'b0);
                guard++;
            end
            chk("stream_accepts", 64'(n_acc), 64'd8);
            repeat (4) idle(1'b1);

            // Flush at every point of an operation's life.
            for (int k = 1; k <= lat(d) + 1; k++) begin
                step(1'b1, 1'($urandom), {$urandom, $urandom}, 5'd9, 1'b1, 1'b0, 1'b0);
                for (int j = 1; j < k; j++) idle(1'b0);
                step(1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b1, 1'b0);
                idle(1'b1);
                idle(1'b1);
            end

            // Flush coincident with in_valid must not accept.
            step(1'b1, 1'b0, 64'h1, 5'd5, 1'b1, 1'b1, 1'b0);
            repeat (4) idle(1'b1);

            // Reset mid-operation, then a clean op.
            step(1'b1, 1'b0, {$urandom, $urandom}, 5'd11, 1'b1, 1'b0, 1'b0);
            idle(1'b0);
            step(1'b1, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
            step(1'b1, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
            idle(1'b1);
            run_one(1'b0, 64'h1, 5'd1, ext(d, 32'h0002_0201));

            step(1'b1, 1'b1, {$urandom, $urandom}, 5'd12, 1'b0, 1'b0, 1'b0);
            repeat (4) idle(1'b0);
            step(1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
            idle(1'b1);
            run_one(1'b1, 64'h1, 5'd1, ext(d, 32'h0080_8001));

            // Randomized traffic with backpressure, flushes and resets.
            repeat (300) begin
                step($urandom_range(0, 99) < 60, 1'($urandom), {$urandom, $urandom},
                     5'($urandom), $urandom_range(0, 99) < 70,
                     $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2);
            end
            step(1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ssm3_fu.md
# ssm3_fu

Parametrised, sequential functional unit executing the scalar SM3 permutation instructions ssm3.p0 and ssm3.p1 inside the execute stage. It generalises the scalar SM3 semantics to XLEN 32 or 64 and offers two microarchitectures:
- a single-register pipeline (throughput 1/cycle);
- an area-saving iterative datapath sharing one rotator over three cycles.

Decoupled valid/ready handshakes sit on both sides, and a flush input supports pipeline squash.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32, 64.
- ITERATIVE, 0: 0 = single-stage pipelined; 1 = iterative multi-cycle FSM.

Ports:
- g_clk  in  1  clock; all state updates on rising edge.
- g_reset  in  1  reset, synchronous and active-high.
- flush  in  1  squash any accepted or in-flight operation.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  1  0 = P0, 1 = P1.
- in_rs1  in  XLEN  source operand.
- in_rd  in  5  destination tag, carried to output.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  XLEN  result.
- out_rd  out  5  tag of result.

## Operation
- Operand source: x = in_rs1[31:0]; in_rs1[XLEN-1:32] is ignored.
- P0 = x ^ rol32(x,9) ^ rol32(x,17).
- P1 = x ^ rol32(x,15) ^ rol32(x,23).
- XLEN=64: out_result = sign-extension of the 32-bit result from bit 31.
- in_rd == 0: out_result = 0, and out_valid still asserts with out_rd = 0.
- Accept event: in_valid && in_ready at a rising edge.
- Output transfer: out_valid && out_ready at a rising edge.
- out_result and out_rd stay stable while out_valid=1 and out_ready=0.
- ITERATIVE=0:
  - One output register.
  - in_ready = !g_reset && !flush && (!out_valid || out_ready).
  - Back-to-back accepts are allowed when the consumer drains each cycle.
- ITERATIVE=1, state machine IDLE -> ROT_A -> ROT_B -> DONE -> IDLE:
  - IDLE: in_ready = !g_reset && !flush. On accept, capture x, op and rd; acc <= x.
  - ROT_A: acc <= acc ^ rol32(x, op ? 15 : 9).
  - ROT_B: acc <= acc ^ rol32(x, op ? 23 : 17).
  - DONE: out_valid=1; on out_ready go to IDLE.
  - in_ready=0 in every state except IDLE.
  - Only one rotator and one XOR are permitted.
- Flush:
  - Takes priority over every other event; in_ready is forced low while flush=1.
  - Next cycle: out_valid=0, FSM = IDLE, captured operation discarded.
  - A result with out_valid && out_ready && flush in the same cycle counts as transferred; the consumer owns squash semantics.
- Reset, held for at least one edge:
  - out_valid=0, out_result=0, out_rd=0, FSM=IDLE, acc=0.
  - in_ready=0 while g_reset=1 and 1 in the first cycle after release.
- Operands are sampled only at accept. Changes to in_rs1, in_op or in_rd afterwards have no effect.

## Timing
- ITERATIVE=0:
  - Accept at edge E makes out_valid=1 in the cycle after E (latency 1).
  - With out_ready stuck 0, the unit holds one result and in_ready=0.
- ITERATIVE=1:
  - Accept at edge E: ROT_A after E, ROT_B after E+1, DONE (out_valid=1) after E+2 (latency 3).
  - Earliest next accept is the edge after the transfer edge, giving a sustained throughput of 1 per 4 cycles.
- in_ready and out_valid are combinational from state/flush/reset only. There is no combinational path from in_valid to in_ready, or from in_rs1 to out_result.
- Both variants must produce bit-identical out_result/out_rd sequences for identical accepted inputs.

## Test plan
- Basic values, XLEN=32, both ITERATIVE settings, rd=1:
  - P0(0x00000001) -> 0x00020201.
  - P1(0x00000001) -> 0x00808001.
  - P0(0xFFFFFFFF) -> 0xFFFFFFFF.
- XLEN=64:
  - P0(0xDEADBEEF_80000000) -> 0xFFFFFFFF_80010100.
  - P0(0xDEADBEEF_00000001) -> 0x00000000_00020201.
- rd=0 with P1(0x12345678) -> out_valid=1, out_rd=0, out_result=0.
- Backpressure:
  - ITERATIVE=0: hold out_ready=0 for 5 cycles after accept. Result stays stable and in_ready=0 throughout. Then stream 8 ops with out_ready=1: 8 results on 8 consecutive cycles.
  - ITERATIVE=1: same stream gives out_valid exactly 3 edges after each accept.
- Flush in ROT_B (ITERATIVE=1), and flush one cycle after accept (ITERATIVE=0) -> out_valid=0 next cycle, FSM IDLE, no stale result ever appears. Flush coincident with in_valid -> no accept.
- Reset asserted mid-operation (ROT_A, and DONE with out_ready=0) -> next cycle all outputs 0, in_ready=0 during reset, first accept after release computes correctly.
